// File: rtl/ef_i2c_seq.sv
// Register-access sequencer for the EF_I2C byte-level master core.
// Expands one "read/write N bytes at register R of device D" request into core commands and streams.
module ef_i2c_seq #(
  parameter  int MAX_LEN        = 16,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int LEN_W          = $clog2(MAX_LEN),
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [6:0]       req_dev,
  input  logic [7:0]       req_reg,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  input  logic             rd_ready,
  output logic             done,
  output logic [1:0]       err,
  output logic             busy,
  // core side
  output logic [6:0]       cmd_address,
  output logic             cmd_start,
  output logic             cmd_read,
  output logic             cmd_write,
  output logic             cmd_write_multiple,
  output logic             cmd_stop,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_last,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_last,
  output logic             rx_ready,
  input  logic             core_busy,
  input  logic             missed_ack
);

  typedef enum logic [3:0] {
    IDLE,
    CMD_WM,
    CMD_W1,
    TX_REG,
    TX_DATA,
    CMD_RD,
    RX,
    ABORT,
    WAIT_IDLE,
    DONE
  } state_t;

  typedef struct packed {
    logic start;
    logic read;
    logic write;
    logic write_multiple;
    logic stop;
  } cmd_t;

  localparam cmd_t CMD_WRITE_MULTI = cmd_t'(5'b10011);
  localparam cmd_t CMD_WRITE_ONE   = cmd_t'(5'b10100);
  localparam cmd_t CMD_STOP_ONLY   = cmd_t'(5'b00001);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic cmd_t read_cmd(input logic first, input logic last);
    cmd_t c;
    c       = '0;
    c.start = first;
    c.read  = 1'b1;
    c.stop  = last;
    return c;
  endfunction

  state_t           state;
  cmd_t             cmd_q;
  logic             rw_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [TO_W-1:0]  timer;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             tx_last_q;

  logic cmd_hs, tx_hs, rx_hs;
  logic cnt_at_len;
  logic nack_hit, timeout_hit;

  // The core reports the final-byte marker itself; this sequencer tracks the count on its own.
  logic unused_rx_last;
  assign unused_rx_last = rx_last;

  assign cmd_start          = cmd_q.start;
  assign cmd_read           = cmd_q.read;
  assign cmd_write          = cmd_q.write;
  assign cmd_write_multiple = cmd_q.write_multiple;
  assign cmd_stop           = cmd_q.stop;

  assign cmd_hs     = cmd_valid & cmd_ready;
  assign tx_hs      = tx_valid & tx_ready;
  assign rx_hs      = rx_valid & rx_ready;
  assign cnt_at_len = (cnt == len_q);

  // A NACK already being handled must not re-trigger the abort while the stop drains.
  assign nack_hit = missed_ack && (err != ERR_NACK) &&
                    (state != IDLE) && (state != DONE) && (state != ABORT);

  // Fires on the edge where the stall counter would reach TIMEOUT_CYCLES.
  assign timeout_hit = (state != IDLE) && (state != DONE) && !(cmd_hs || tx_hs || rx_hs) &&
                       (timer == TO_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every output of this block gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    tx_data  = tx_data_q;
    tx_valid = tx_valid_q;
    tx_last  = tx_last_q;
    wr_ready = 1'b0;
    rd_data  = '0;
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    rx_ready = 1'b0;
    case (state)
      TX_DATA: begin
        tx_data  = wr_data;
        tx_valid = wr_valid;
        tx_last  = cnt_at_len;
        wr_ready = tx_ready;
      end
      RX: begin
        rd_data  = rx_data;
        rd_valid = rx_valid;
        rd_last  = cnt_at_len;
        rx_ready = rd_ready;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register here
  // sees the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= ERR_OK;
      cmd_valid   <= 1'b0;
      cmd_q       <= '0;
      cmd_address <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      rw_q        <= 1'b0;
      reg_q       <= '0;
      len_q       <= '0;
      cnt         <= '0;
      timer       <= '0;
    end else begin
      done <= 1'b0;

      if (state == IDLE || cmd_hs || tx_hs || rx_hs) timer <= '0;
      else                                           timer <= timer + TO_W'(1);

      if (nack_hit) begin
        err        <= ERR_NACK;
        state      <= ABORT;
        tx_valid_q <= 1'b0;
        // A command the core has not yet taken stays on the bus; the stop follows it.
        if (!(cmd_valid && !cmd_ready)) begin
          cmd_valid <= 1'b1;
          cmd_q     <= CMD_STOP_ONLY;
        end
      end else if (timeout_hit) begin
        err        <= ERR_TIMEOUT;
        state      <= DONE;
        done       <= 1'b1;
        cmd_valid  <= 1'b0;
        tx_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              rw_q        <= req_rw;
              reg_q       <= req_reg;
              len_q       <= req_len;
              cmd_address <= req_dev;
              cnt         <= '0;
              err         <= ERR_OK;
              busy        <= 1'b1;
              req_ready   <= 1'b0;
              cmd_valid   <= 1'b1;
              cmd_q       <= req_rw ? CMD_WRITE_ONE : CMD_WRITE_MULTI;
              state       <= req_rw ? CMD_W1 : CMD_WM;
            end
          end

          CMD_WM, CMD_W1: begin
            if (cmd_hs) begin
              cmd_valid  <= 1'b0;
              tx_data_q  <= reg_q;
              tx_valid_q <= 1'b1;
              tx_last_q  <= rw_q;
              state      <= TX_REG;
            end
          end

          TX_REG: begin
            if (tx_hs) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              if (rw_q) begin
                cmd_valid <= 1'b1;
                cmd_q     <= read_cmd(1'b1, cnt_at_len);
                state     <= CMD_RD;
              end else begin
                state <= TX_DATA;
              end
            end
          end

          TX_DATA: begin
            if (tx_hs) begin
              if (cnt_at_len) state <= WAIT_IDLE;
              else            cnt   <= cnt + LEN_W'(1);
            end
          end

          CMD_RD: begin
            if (cmd_hs) begin
              cmd_valid <= 1'b0;
              state     <= RX;
            end
          end

          RX: begin
            if (rx_hs) begin
              if (cnt_at_len) begin
                state <= WAIT_IDLE;
              end else begin
                cnt       <= cnt + LEN_W'(1);
                cmd_valid <= 1'b1;
                cmd_q     <= read_cmd(1'b0, (cnt + LEN_W'(1)) == len_q);
                state     <= CMD_RD;
              end
            end
          end

          ABORT: begin
            if (cmd_hs) begin
              if (cmd_q == CMD_STOP_ONLY) begin
                cmd_valid <= 1'b0;
                state     <= WAIT_IDLE;
              end else begin
                cmd_q <= CMD_STOP_ONLY;
              end
            end else if (!cmd_valid) begin
              cmd_valid <= 1'b1;
              cmd_q     <= CMD_STOP_ONLY;
            end
          end

          WAIT_IDLE: begin
            if (!core_busy) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end

          DONE: begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ef_i2c_seq.sv
// Directed self-checking bench for ef_i2c_seq; the bench plays both the requester and the I2C core.
module tb_ef_i2c_seq;

  localparam int TO    = 100;
  localparam int LIMIT = 300;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0;
  logic [3:0] req_len = '0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_last, rd_ready = 1'b0;
  logic       done, busy;
  logic [1:0] err;
  logic [6:0] cmd_address;
  logic       cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
  logic       cmd_valid, cmd_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_last = 1'b0, rx_ready;
  logic       core_busy = 1'b0, missed_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_beats = 0;
  int wr_beats = 0;

  always #5 clk_i = ~clk_i;

  ef_i2c_seq #(.MAX_LEN(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .err(err), .busy(busy),
    .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
    .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .core_busy(core_busy), .missed_ack(missed_ack)
  );

  // Stream beats counted mid-cycle, where valid/ready are settled.
  always @(negedge clk_i) begin
    if (rd_valid && rd_ready) rd_beats++;
    if (wr_valid && wr_ready) wr_beats++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // {req_ready, busy, done, err, cmd_valid, cmd flags, cmd_address, tx_valid, tx_last, tx_data,
  //  rd_valid, rd_last, wr_ready, rx_ready}: only req_ready is 1 at reset.
  task automatic check_reset_vals(input string tag);
    check(tag, {req_ready, busy, done, err, cmd_valid, cmd_start, cmd_read, cmd_write,
                cmd_write_multiple, cmd_stop, cmd_address, tx_valid, tx_last, tx_data,
                rd_valid, rd_last, wr_ready, rx_ready}, 32'h8000_0000);
  endtask

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [3:0] len);
    req_rw = rw; req_dev = dev; req_reg = rg; req_len = len; req_valid = 1'b1;
    #1;
    check("req_ready_idle", 32'(req_ready), 1);
    tick;
    req_valid = 1'b0;
    check("accept_busy_cmd", 32'({busy, cmd_valid, req_ready}), 32'(3'b110));
  endtask

  task automatic wait_cmd(output logic [4:0] flags, output logic [6:0] addr);
    #1;
    for (int n = 0; n < LIMIT && !cmd_valid; n++) tick;
    check("cmd_valid_seen", 32'(cmd_valid), 1);
    flags = {cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop};
    addr  = cmd_address;
    cmd_ready = 1'b1;
    tick;
    cmd_ready = 1'b0;
  endtask

  task automatic accept_tx(output logic [7:0] data, output logic last);
    #1;
    for (int n = 0; n < LIMIT && !tx_valid; n++) tick;
    check("tx_valid_seen", 32'(tx_valid), 1);
    data = tx_data;
    last = tx_last;
    tx_ready = 1'b1;
    tick;
    tx_ready = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] exp_err, input string tag);
    #1;
    for (int n = 0; n < LIMIT && !done; n++) tick;
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    tick;
    check({tag, "_back_idle"}, 32'({busy, req_ready, done}), 32'(3'b010));
  endtask

  // Write len+1 bytes base, base+0x11, ... to register rg of device dev.
  task automatic do_write(input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] len,
                          input logic [7:0] base);
    logic [4:0] f;
    logic [6:0] a;
    logic [7:0] d;
    logic       l;
    logic [7:0] b;
    int         w0;
    w0 = wr_beats;
    b = base;
    wr_data = b; wr_valid = 1'b1;
    send_req(1'b0, dev, rg, len);
    wait_cmd(f, a);
    check("wr_cmd_flags", 32'(f), 32'(5'b10011));
    check("wr_cmd_addr", 32'(a), 32'(dev));
    core_busy = 1'b1;
    accept_tx(d, l);
    check("wr_reg_byte", 32'({l, d}), 32'({1'b0, rg}));
    for (int i = 0; i <= int'(len); i++) begin
      accept_tx(d, l);
      check("wr_data_byte", 32'({l, d}), 32'({i == int'(len), b}));
      b = b + 8'h11;
      wr_data = b;
    end
    wr_valid = 1'b0;
    repeat (3) tick;
    check("wr_wait_core", 32'(done), 0);
    core_busy = 1'b0;
    wait_done(2'b00, "wr");
    check("wr_beats", 32'(wr_beats - w0), 32'(int'(len) + 1));
  endtask

  // Read len+1 bytes 0x11, 0x22, ...; rd_ready held low for `stall` cycles before each byte.
  task automatic do_read(input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] len,
                         input int stall);
    logic [4:0] f;
    logic [6:0] a;
    logic [7:0] d;
    logic       l;
    logic [7:0] b;
    int         r0;
    int         bad;
    r0 = rd_beats;
    send_req(1'b1, dev, rg, len);
    wait_cmd(f, a);
    check("rd_cmd_w1_flags", 32'(f), 32'(5'b10100));
    check("rd_cmd_addr", 32'(a), 32'(dev));
    core_busy = 1'b1;
    accept_tx(d, l);
    check("rd_reg_byte", 32'({l, d}), 32'({1'b1, rg}));
    for (int i = 0; i <= int'(len); i++) begin
      wait_cmd(f, a);
      check("rd_cmd_flags", 32'(f), 32'({i == 0, 1'b1, 1'b0, 1'b0, i == int'(len)}));
      b = 8'((i + 1) * 17);
      rx_data = b; rx_valid = 1'b1; rx_last = (i == int'(len)); rd_ready = 1'b0;
      #1;
      bad = 0;
      for (int s = 0; s < stall; s++) begin
        if (rx_ready !== 1'b0 || rd_valid !== 1'b1) bad++;
        tick;
      end
      if (stall > 0) check("rd_stall_hold", 32'(bad), 0);
      rd_ready = 1'b1;
      #1;
      check("rd_beat", 32'({rd_valid, rx_ready, rd_last, rd_data}),
            32'({1'b1, 1'b1, i == int'(len), b}));
      tick;
      rx_valid = 1'b0; rd_ready = 1'b0; rx_last = 1'b0;
    end
    core_busy = 1'b0;
    wait_done(2'b00, "rd");
    check("rd_beats", 32'(rd_beats - r0), 32'(int'(len) + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0] f;
    logic [6:0] a;
    logic [7:0] d;
    logic       l;
    int         w0;
    int         cyc;

    repeat (3) tick;
    check_reset_vals("reset_state");
    rst_i = 1'b0;
    tick;
    check_reset_vals("idle_after_reset");

    // Plain write and reads, then a read throttled by the requester.
    do_write(7'h50, 8'h10, 4'd1, 8'hAA);
    do_read(7'h50, 8'h20, 4'd2, 0);
    do_read(7'h51, 8'h40, 4'd1, 10);

    // NACK right after the register byte of a write.
    wr_data = 8'hC1; wr_valid = 1'b1;
    send_req(1'b0, 7'h50, 8'h30, 4'd1);
    wait_cmd(f, a);
    check("nack_cmd_flags", 32'(f), 32'(5'b10011));
    core_busy = 1'b1;
    accept_tx(d, l);
    check("nack_reg_byte", 32'({l, d}), 32'({1'b0, 8'h30}));
    w0 = wr_beats;
    missed_ack = 1'b1;
    tick;
    missed_ack = 1'b0;
    check("nack_err_set", 32'(err), 1);
    check("nack_wr_ready", 32'(wr_ready), 0);
    wait_cmd(f, a);
    check("nack_stop_only", 32'(f), 32'(5'b00001));
    repeat (3) tick;
    check("nack_single_stop", 32'({cmd_valid, done}), 0);
    check("nack_no_wr_consumed", 32'(wr_beats - w0), 0);
    core_busy = 1'b0;
    wait_done(2'b01, "nack");
    wr_valid = 1'b0;

    // Core never accepts the command.
    send_req(1'b0, 7'h50, 8'h70, 4'd0);
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      tick;
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), TO);
    check("timeout_err", 32'(err), 2);
    check("timeout_no_stop", 32'(cmd_valid), 0);
    tick;
    check("timeout_idle", 32'({busy, req_ready}), 32'(2'b01));

    // Reset in the middle of a read data beat.
    send_req(1'b1, 7'h52, 8'h60, 4'd3);
    wait_cmd(f, a);
    core_busy = 1'b1;
    accept_tx(d, l);
    wait_cmd(f, a);
    check("rst_pre_flags", 32'(f), 32'(5'b11000));
    rx_data = 8'h99; rx_valid = 1'b1;
    #1;
    check("rst_in_rx", 32'({rd_valid, rd_data}), 32'({1'b1, 8'h99}));
    rst_i = 1'b1;
    #1;
    check_reset_vals("mid_rx_reset");
    rx_valid = 1'b0; core_busy = 1'b0;
    tick;
    rst_i = 1'b0;
    tick;
    do_write(7'h3C, 8'h05, 4'd2, 8'hD0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ef_i2c_seq.md
# ef_i2c_seq

Register-access sequencer sitting between a bus-side requester (firmware FIFO or DMA) and the EF_I2C byte-level master core command/data streams. It turns one request of the form "read or write N bytes at register R of device D" into the exact core command sequence: start, register address, data, repeated start, stop. It collects read bytes, detects NACK and stall, and reports one completion status per request.

## Interface
- MAX_LEN, 16: maximum bytes per request; `req_len` encodes length-1 in clog2(MAX_LEN) bits (4 at default).
- TIMEOUT_CYCLES, 65535: cycles without any handshake progress before a timeout abort; counter width is clog2(TIMEOUT_CYCLES+1).
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid / req_ready  in/out  1  request handshake.
- req_rw  in  1  1 = read, 0 = write.
- req_dev  in  7  device address.
- req_reg  in  8  register address.
- req_len  in  4  byte count minus 1.
- wr_data / wr_valid / wr_ready  in/in/out  8/1/1  write payload stream.
- rd_data / rd_valid / rd_last / rd_ready  out/out/out/in  8/1/1/1  read payload stream.
- done  out  1  one-cycle completion pulse.
- err  out  2  status: 00 ok, 01 NACK, 10 timeout.
- busy  out  1  request in flight.
- cmd_address  out  7  core command address.
- cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop  out  1 each  core command flags.
- cmd_valid / cmd_ready  out/in  1  core command handshake.
- tx_data / tx_valid / tx_last / tx_ready  out/out/out/in  8/1/1/1  core write-data stream.
- rx_data / rx_valid / rx_last / rx_ready  in/in/in/out  8/1/1/1  core read-data stream.
- core_busy  in  1  core transaction active.
- missed_ack  in  1  core NACK flag.

## Operation
- States: IDLE, CMD_WM, CMD_W1, TX_REG, TX_DATA, CMD_RD, RX, ABORT, WAIT_IDLE, DONE.
- IDLE: `req_ready`=1. On `req_valid`, latch dev/reg/len/rw, clear byte counter and `err`, then go to CMD_WM (write) or CMD_W1 (read).
- Write path:
  - CMD_WM issues start=1, write_multiple=1, stop=1.
  - TX_REG sends `req_reg` with tx_last=0.
  - TX_DATA is a combinational pass-through: `tx_data`=`wr_data`, `tx_valid`=`wr_valid`, `wr_ready`=`tx_ready`. `tx_last`=1 when counter==len. On the last beat go to WAIT_IDLE.
- Read path:
  - CMD_W1 issues start=1, write=1, stop=0.
  - TX_REG sends `req_reg` with tx_last=1.
  - CMD_RD issues read=1, with start=1 only for byte 0 and stop=1 only when counter==len.
  - RX passes through: `rd_data`=`rx_data`, `rd_valid`=`rx_valid`, `rx_ready`=`rd_ready`, `rd_last`=(counter==len). After each beat, increment the counter and return to CMD_RD. After the final beat go to WAIT_IDLE.
- All commands drive `cmd_address`=latched dev. Unused flags are 0. `cmd_valid` holds until `cmd_ready`.
- WAIT_IDLE: wait for `core_busy`=0, then go to DONE.
- DONE: pulse `done` for one cycle, then go to IDLE.
- NACK: `missed_ack` sampled high in any state other than IDLE/DONE/ABORT sets `err`=01 and goes to ABORT. ABORT issues a stop-only command (stop=1, all other flags 0), then goes to WAIT_IDLE. Unsent write bytes are not consumed; the requester flushes them.
- Timeout: the counter clears on any cmd/tx/rx handshake and in IDLE, and increments otherwise. Reaching TIMEOUT_CYCLES sets `err`=10 and goes directly to DONE, with no stop issued.
- NACK and timeout in the same cycle: NACK wins.
- `err` holds its value until the next request is accepted. `busy` = state != IDLE.

## Timing
- Reset values:
  - State IDLE; `req_ready`=1.
  - 0 for all other outputs: `done`, `err`, `busy`, `cmd_valid`, all cmd flags, `cmd_address`, `tx_*`, `rd_valid`, `rd_last`, `wr_ready`, `rx_ready`.
- Reset mid-operation returns to IDLE immediately with no stop issued; the core shares `rst_i`.
- Request accepted at edge N: `busy`=1 and `cmd_valid`=1 from cycle N+1.
- The state advances on the edge where a handshake completes. A new command is never presented before the previous handshake completes.
- `done` rises one cycle after WAIT_IDLE sees `core_busy`=0, or one cycle after the timeout hit. `req_ready` returns the cycle after `done`.
- Stream handshakes follow valid/ready: valid never depends on ready, and data is held stable while stalled.

## Test plan
- Write dev 0x50, reg 0x10, len 1 (2 bytes: 0xAA, 0xBB) -> cmds: {start, write_multiple, stop}; tx 0x10, 0xAA, 0xBB with tx_last on 0xBB; `done` with err=00.
- Read dev 0x50, reg 0x20, len 2 -> {start, write} + tx 0x20 (last); then 3 reads with start on the first and stop on the third; rx 0x11/0x22/0x33 appear on `rd_data`, rd_last on 0x33; err=00.
- Read with `rd_ready` low for 10 cycles per byte -> `rx_ready` low for the same cycles; no byte lost or duplicated; no timeout.
- `missed_ack` pulsed after the address byte of a write -> err=01; one stop-only command; `done` after `core_busy` falls; remaining `wr_data` untouched.
- TIMEOUT_CYCLES=100, `cmd_ready` held 0 -> `done` with err=10 at 100 cycles after `cmd_valid` rose; `busy` then 0.
- `rst_i` asserted during RX -> same-cycle IDLE, all outputs at reset values; a subsequent write request completes normally.
